// File: rtl/pe_mac_sequencer.sv
// Sequencer for a single-PE MAC datapath: streams operand pairs into the PE and
// accumulates the sign-extended truncated products into a dot-product result.
module pe_mac_sequencer #(
  parameter int DATA_WIDTH = 16,
  parameter int ACC_WIDTH  = 32,
  parameter int LEN_WIDTH  = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  start_i,
  input  logic [LEN_WIDTH-1:0]  len_i,
  output logic                  busy_o,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  input  logic [DATA_WIDTH-1:0] in_a_i,
  input  logic [DATA_WIDTH-1:0] in_b_i,
  output logic [DATA_WIDTH-1:0] pe_operand_a_o,
  output logic [DATA_WIDTH-1:0] pe_operand_b_o,
  input  logic [DATA_WIDTH-1:0] pe_result_i,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic [ACC_WIDTH-1:0]  out_acc_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t                 state_r;
  logic [LEN_WIDTH-1:0]   remaining_r;
  logic                   s1_v_r;
  logic [ACC_WIDTH-1:0]   acc_r;
  logic                   in_hs_s;

  function automatic logic [ACC_WIDTH-1:0] sext_result(input logic [DATA_WIDTH-1:0] v);
    return ACC_WIDTH'($signed(v));
  endfunction

  assign in_hs_s   = in_valid_i && in_ready_o;
  assign out_acc_o = acc_r;

  // Job FSM, operand stage and accumulator; handshake flags are registered from the next state.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_r        <= IDLE;
      remaining_r    <= '0;
      s1_v_r         <= 1'b0;
      acc_r          <= '0;
      pe_operand_a_o <= '0;
      pe_operand_b_o <= '0;
      busy_o         <= 1'b0;
      in_ready_o     <= 1'b0;
      out_valid_o    <= 1'b0;
    end else begin
      // The product of the pair loaded last edge is consumed now; a new load re-arms s1_v.
      if (s1_v_r) begin
        acc_r <= acc_r + sext_result(pe_result_i);
      end else begin
        acc_r <= acc_r;
      end
      s1_v_r <= 1'b0;

      case (state_r)
        IDLE: begin
          if (start_i) begin
            acc_r       <= '0;
            remaining_r <= len_i;
            busy_o      <= 1'b1;
            if (len_i != '0) begin
              state_r    <= RUN;
              in_ready_o <= 1'b1;
            end else begin
              state_r     <= DONE;
              out_valid_o <= 1'b1;
            end
          end else begin
            state_r <= IDLE;
          end
        end
        RUN: begin
          if (in_hs_s) begin
            pe_operand_a_o <= in_a_i;
            pe_operand_b_o <= in_b_i;
            s1_v_r         <= 1'b1;
            remaining_r    <= remaining_r - LEN_WIDTH'(1);
            if (remaining_r == LEN_WIDTH'(1)) begin
              state_r    <= DRAIN;
              in_ready_o <= 1'b0;
            end else begin
              state_r <= RUN;
            end
          end else begin
            state_r <= RUN;
          end
        end
        DRAIN: begin
          state_r     <= DONE;
          in_ready_o  <= 1'b0;
          out_valid_o <= 1'b1;
        end
        DONE: begin
          if (out_ready_i) begin
            state_r     <= IDLE;
            out_valid_o <= 1'b0;
            busy_o      <= 1'b0;
          end else begin
            state_r <= DONE;
          end
        end
        default: begin
          state_r     <= IDLE;
          busy_o      <= 1'b0;
          in_ready_o  <= 1'b0;
          out_valid_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pe_mac_sequencer.sv
// Scoreboard bench for pe_mac_sequencer with a behavioural truncating signed PE.
module tb_pe_mac_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_i;
  logic [7:0]  len_i;
  logic        busy_o;
  logic        in_valid_i;
  logic        in_ready_o;
  logic [15:0] in_a_i;
  logic [15:0] in_b_i;
  logic [15:0] pe_operand_a_o;
  logic [15:0] pe_operand_b_o;
  logic [15:0] pe_result_i;
  logic        out_valid_o;
  logic        out_ready_i;
  logic [31:0] out_acc_o;

  logic signed [31:0] pe_prod_s;
  logic signed [15:0] pa [8];
  logic signed [15:0] pb [8];
  logic [31:0]        exp_q [$];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pe_mac_sequencer #(.DATA_WIDTH(16), .ACC_WIDTH(32), .LEN_WIDTH(8)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start_i), .len_i(len_i), .busy_o(busy_o),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o), .in_a_i(in_a_i), .in_b_i(in_b_i),
    .pe_operand_a_o(pe_operand_a_o), .pe_operand_b_o(pe_operand_b_o),
    .pe_result_i(pe_result_i), .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .out_acc_o(out_acc_o)
  );

  // PE model: signed product truncated to the operand width.
  always_comb begin
    pe_prod_s   = $signed(pe_operand_a_o) * $signed(pe_operand_b_o);
    pe_result_i = pe_prod_s[15:0];
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check_val({tag, "_busy"}, {31'd0, busy_o}, 32'd0);
    check_val({tag, "_in_ready"}, {31'd0, in_ready_o}, 32'd0);
    check_val({tag, "_out_valid"}, {31'd0, out_valid_o}, 32'd0);
    check_val({tag, "_op_a"}, {16'd0, pe_operand_a_o}, 32'd0);
    check_val({tag, "_op_b"}, {16'd0, pe_operand_b_o}, 32'd0);
    check_val({tag, "_acc"}, out_acc_o, 32'd0);
  endtask

  // Expected dot product of the first n entries of pa/pb with truncated products.
  function automatic logic [31:0] model_sum(input int n);
    logic [31:0]        s;
    logic signed [31:0] p;
    logic [15:0]        t;
    s = 32'd0;
    for (int i = 0; i < n; i++) begin
      p = pa[i] * pb[i];
      t = p[15:0];
      s = s + 32'($signed(t));
    end
    return s;
  endfunction

  task automatic start_job(input int n);
    exp_q.push_back(model_sum(n));
    start_i = 1'b1;
    len_i   = 8'(n);
    @(negedge clk);
    start_i = 1'b0;
    check_val("start_busy", {31'd0, busy_o}, 32'd1);
  endtask

  task automatic send_pair(input logic [15:0] a, input logic [15:0] b);
    int t = 0;
    in_valid_i = 1'b1;
    in_a_i     = a;
    in_b_i     = b;
    while (!in_ready_o && t < 20) begin
      @(negedge clk);
      t++;
    end
    if (t >= 20) check_val("ready_timeout", 32'd0, 32'd1);
    @(negedge clk);
    in_valid_i = 1'b0;
    check_val("op_a_load", {16'd0, pe_operand_a_o}, {16'd0, a});
    check_val("op_b_load", {16'd0, pe_operand_b_o}, {16'd0, b});
  endtask

  // Feeds n pairs with gap idle cycles between them and checks the 2-cycle result latency.
  task automatic run_job(input int n, input int gap);
    start_job(n);
    for (int i = 0; i < n; i++) begin
      send_pair(pa[i], pb[i]);
      if (i < n - 1) begin
        for (int g = 0; g < gap; g++) begin
          @(negedge clk);
          check_val("gap_hold_a", {16'd0, pe_operand_a_o}, {16'd0, pa[i]});
          check_val("gap_hold_b", {16'd0, pe_operand_b_o}, {16'd0, pb[i]});
        end
      end
    end
    check_val("drain_no_valid", {31'd0, out_valid_o}, 32'd0);
    check_val("drain_no_ready", {31'd0, in_ready_o}, 32'd0);
    @(negedge clk);
    check_val("latency_valid", {31'd0, out_valid_o}, 32'd1);
  endtask

  task automatic get_result(input string tag);
    int t = 0;
    while (!out_valid_o && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (t >= 50) check_val({tag, "_timeout"}, 32'd0, 32'd1);
    else if (exp_q.size() == 0) check_val({tag, "_sb_empty"}, 32'd0, 32'd1);
    else check_val(tag, out_acc_o, exp_q.pop_front());
  endtask

  task automatic release_result(input string tag);
    out_ready_i = 1'b1;
    @(negedge clk);
    out_ready_i = 1'b0;
    check_val({tag, "_valid_drop"}, {31'd0, out_valid_o}, 32'd0);
    check_val({tag, "_idle"}, {31'd0, busy_o}, 32'd0);
  endtask

  initial begin
    logic [31:0] held;
    rst = 1'b1; start_i = 1'b0; len_i = 8'd0; in_valid_i = 1'b0;
    in_a_i = 16'd0; in_b_i = 16'd0; out_ready_i = 1'b0;
    #12;
    check_idle_outputs("reset");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // 1: back-to-back pairs, negative total
    pa[0] = 16'sd1;  pb[0] = 16'sd2;
    pa[1] = 16'sd3;  pb[1] = 16'sd4;
    pa[2] = -16'sd2; pb[2] = 16'sd5;
    pa[3] = 16'sd7;  pb[3] = -16'sd1;
    run_job(4, 0);
    check_val("t1_literal", out_acc_o, 32'hFFFF_FFFD);
    get_result("t1_acc");
    release_result("t1");

    // 2: truncated product
    pa[0] = 16'sd300; pb[0] = 16'sd300;
    run_job(1, 0);
    check_val("t2_literal", out_acc_o, 32'd24464);
    get_result("t2_acc");
    release_result("t2");

    // 3: in_valid gaps between pairs
    for (int i = 0; i < 3; i++) begin
      pa[i] = 16'sd2; pb[i] = 16'sd2;
    end
    run_job(3, 2);
    check_val("t3_literal", out_acc_o, 32'd12);
    get_result("t3_acc");
    release_result("t3");

    // 4: zero-length job
    exp_q.push_back(32'd0);
    start_i = 1'b1; len_i = 8'd0;
    @(negedge clk);
    start_i = 1'b0;
    check_val("t4_valid", {31'd0, out_valid_o}, 32'd1);
    check_val("t4_no_ready", {31'd0, in_ready_o}, 32'd0);
    get_result("t4_acc");
    release_result("t4");

    // 5: back-pressure in DONE with a stray start
    pa[0] = 16'sd5;  pb[0] = 16'sd6;
    pa[1] = -16'sd1; pb[1] = 16'sd7;
    run_job(2, 0);
    held = out_acc_o;
    check_val("t5_literal", held, 32'd23);
    for (int k = 0; k < 10; k++) begin
      start_i = (k == 3);
      len_i   = 8'd4;
      @(negedge clk);
      check_val("t5_hold_valid", {31'd0, out_valid_o}, 32'd1);
      check_val("t5_hold_acc", out_acc_o, held);
      check_val("t5_hold_no_ready", {31'd0, in_ready_o}, 32'd0);
    end
    start_i = 1'b0;
    get_result("t5_acc");
    release_result("t5");

    // 6: reset mid-job, then a fresh job
    for (int i = 0; i < 5; i++) begin
      pa[i] = 16'(i + 3); pb[i] = 16'(i + 1);
    end
    start_job(5);
    send_pair(pa[0], pb[0]);
    send_pair(pa[1], pb[1]);
    #2 rst = 1'b1;
    #1;
    check_idle_outputs("t6_rst");
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_idle_outputs("t6_after_rst");
    pa[0] = 16'sd4; pb[0] = 16'sd4;
    pa[1] = 16'sd1; pb[1] = 16'sd1;
    run_job(2, 0);
    check_val("t6_literal", out_acc_o, 32'd17);
    get_result("t6_acc");
    release_result("t6");

    check_val("sb_drained", exp_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
